// File: rtl/dzcpu_ucode_sequencer.sv
// rtl/dzcpu_ucode_sequencer.sv - dzcpu micro-sequencer: micro-PC, dispatch tables, end-of-flow and IRQ entry
module dzcpu_ucode_sequencer #(
    parameter int MOP_W           = 8,
    parameter int UPC_W           = 9,
    parameter int UOP_W           = 13,
    parameter int CTRL_LSB        = 9,
    parameter int DEFAULT_FLOW    = 0,
    parameter int NUM_IRQ         = 5,
    parameter int INT_FLOW_BASE   = 448,
    parameter int INT_FLOW_STRIDE = 8
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic [MOP_W-1:0]   iMop,
    input  logic               iMopValid,
    output logic               oMopReq,
    input  logic               iStall,
    input  logic [3:0]         iFlags,
    input  logic               iIme,
    input  logic [NUM_IRQ-1:0] iIrq,
    output logic [NUM_IRQ-1:0] oIrqAck,
    output logic [UPC_W-1:0]   oRomAddr,
    input  logic [UOP_W-1:0]   iRomData,
    output logic [UOP_W-1:0]   oUop,
    output logic               oUopValid,
    output logic               oEof,
    input  logic               iCfgWe,
    input  logic               iCfgSel,
    input  logic [MOP_W-1:0]   iCfgAddr,
    input  logic [UPC_W-1:0]   iCfgData,
    output logic               oUpcOverflow
);

    localparam int TBL_DEPTH = 1 << MOP_W;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        CBWAIT = 2'd2,
        HALT   = 2'd3
    } state_t;

    localparam logic [3:0] C_CONT   = 4'd0;
    localparam logic [3:0] C_EOF    = 4'd1;
    localparam logic [3:0] C_EOF_Z  = 4'd2;
    localparam logic [3:0] C_EOF_NZ = 4'd3;
    localparam logic [3:0] C_EOF_C  = 4'd4;
    localparam logic [3:0] C_EOF_NC = 4'd5;
    localparam logic [3:0] C_JCB    = 4'd6;
    localparam logic [3:0] C_HALT   = 4'd7;

    state_t             state;
    logic [UPC_W-1:0]   upc;
    logic [UPC_W-1:0]   prim_tbl [TBL_DEPTH];
    logic [UPC_W-1:0]   cb_tbl   [TBL_DEPTH];

    logic [3:0]         ctrl;
    logic               flag_z;
    logic               flag_c;
    logic               eof_take;
    logic [UPC_W-1:0]   upc_inc;
    logic               upc_wrap;
    logic               irq_any;
    logic [NUM_IRQ-1:0] irq_onehot;
    logic [UPC_W-1:0]   irq_upc;
    logic               unused_flags;

    assign flag_z       = iFlags[3];
    assign flag_c       = iFlags[0];
    assign unused_flags = ^iFlags[2:1];

    assign ctrl     = iRomData[CTRL_LSB +: 4];
    assign upc_inc  = upc + UPC_W'(1);
    assign upc_wrap = &upc;
    assign irq_any  = |iIrq;

    assign oRomAddr  = upc;
    assign oUopValid = (state == EXEC);
    assign oUop      = oUopValid ? iRomData : '0;
    assign oMopReq   = (state == FETCH) || (state == CBWAIT);

    always_comb begin
        eof_take = 1'b0;
        case (ctrl)
            C_EOF:    eof_take = 1'b1;
            C_EOF_Z:  eof_take = flag_z;
            C_EOF_NZ: eof_take = !flag_z;
            C_EOF_C:  eof_take = flag_c;
            C_EOF_NC: eof_take = !flag_c;
            default:  eof_take = 1'b0;
        endcase
    end

    // Lowest-numbered pending request wins; scan high to low so the last hit is the lowest.
    always_comb begin
        irq_onehot = '0;
        irq_upc    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (iIrq[i]) begin
                irq_onehot    = '0;
                irq_onehot[i] = 1'b1;
                irq_upc       = UPC_W'(INT_FLOW_BASE + i * INT_FLOW_STRIDE);
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state        <= FETCH;
            upc          <= '0;
            oEof         <= 1'b0;
            oIrqAck      <= '0;
            oUpcOverflow <= 1'b0;
            for (int i = 0; i < TBL_DEPTH; i++) begin
                prim_tbl[i] <= UPC_W'(DEFAULT_FLOW);
                cb_tbl[i]   <= UPC_W'(DEFAULT_FLOW);
            end
        end else begin
            oEof    <= 1'b0;
            oIrqAck <= '0;

            // Table reads below see the pre-edge contents, so a same-cycle dispatch uses the old entry.
            if (iCfgWe) begin
                if (iCfgSel) begin
                    cb_tbl[iCfgAddr] <= iCfgData;
                end else begin
                    prim_tbl[iCfgAddr] <= iCfgData;
                end
            end

            case (state)
                FETCH: begin
                    if (iMopValid) begin
                        upc   <= prim_tbl[iMop];
                        state <= EXEC;
                    end
                end
                CBWAIT: begin
                    if (iMopValid) begin
                        upc   <= cb_tbl[iMop];
                        state <= EXEC;
                    end
                end
                HALT: begin
                    if (irq_any) begin
                        upc   <= upc_inc;
                        state <= EXEC;
                        if (upc_wrap) begin
                            oUpcOverflow <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (!iStall) begin
                        if (ctrl == C_JCB) begin
                            state <= CBWAIT;
                        end else if (ctrl == C_HALT) begin
                            state <= HALT;
                        end else if (eof_take) begin
                            oEof <= 1'b1;
                            if (iIme && irq_any) begin
                                upc     <= irq_upc;
                                oIrqAck <= irq_onehot;
                            end else begin
                                state <= FETCH;
                            end
                        end else begin
                            upc <= upc_inc;
                            if (upc_wrap) begin
                                oUpcOverflow <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_dzcpu_ucode_sequencer.sv
// tb/tb_dzcpu_ucode_sequencer.sv - directed self-checking bench for dzcpu_ucode_sequencer
module tb_dzcpu_ucode_sequencer;

    logic        iClock;
    logic        iReset;
    logic [7:0]  iMop;
    logic        iMopValid;
    logic        oMopReq;
    logic        iStall;
    logic [3:0]  iFlags;
    logic        iIme;
    logic [4:0]  iIrq;
    logic [4:0]  oIrqAck;
    logic [8:0]  oRomAddr;
    logic [12:0] iRomData;
    logic [12:0] oUop;
    logic        oUopValid;
    logic        oEof;
    logic        iCfgWe;
    logic        iCfgSel;
    logic [7:0]  iCfgAddr;
    logic [8:0]  iCfgData;
    logic        oUpcOverflow;

    logic [12:0] rom [512];
    int          n_checks;
    int          n_pass;

    assign iRomData = rom[oRomAddr];

    dzcpu_ucode_sequencer dut (
        .iClock       (iClock),
        .iReset       (iReset),
        .iMop         (iMop),
        .iMopValid    (iMopValid),
        .oMopReq      (oMopReq),
        .iStall       (iStall),
        .iFlags       (iFlags),
        .iIme         (iIme),
        .iIrq         (iIrq),
        .oIrqAck      (oIrqAck),
        .oRomAddr     (oRomAddr),
        .iRomData     (iRomData),
        .oUop         (oUop),
        .oUopValid    (oUopValid),
        .oEof         (oEof),
        .iCfgWe       (iCfgWe),
        .iCfgSel      (iCfgSel),
        .iCfgAddr     (iCfgAddr),
        .iCfgData     (iCfgData),
        .oUpcOverflow (oUpcOverflow)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic feed(input logic [7:0] mop);
        iMop      = mop;
        iMopValid = 1'b1;
        step();
        iMopValid = 1'b0;
    endtask

    task automatic cfg(input logic sel, input logic [7:0] addr, input logic [8:0] data);
        iCfgWe   = 1'b1;
        iCfgSel  = sel;
        iCfgAddr = addr;
        iCfgData = data;
        step();
        iCfgWe   = 1'b0;
    endtask

    function automatic logic [12:0] uop(input logic [3:0] c);
        return {c, 9'h000};
    endfunction

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        iReset    = 1'b0;
        iMop      = '0;
        iMopValid = 1'b0;
        iStall    = 1'b0;
        iFlags    = '0;
        iIme      = 1'b0;
        iIrq      = '0;
        iCfgWe    = 1'b0;
        iCfgSel   = 1'b0;
        iCfgAddr  = '0;
        iCfgData  = '0;
        for (int i = 0; i < 512; i++) rom[i] = '0;
        rom[0]   = uop(4'd1);
        rom[2]   = 13'h01a5;
        rom[3]   = uop(4'd9);
        rom[4]   = uop(4'd1);
        rom[5]   = uop(4'd1);
        rom[15]  = uop(4'd6);
        rom[16]  = uop(4'd1);
        rom[19]  = uop(4'd3);
        rom[20]  = uop(4'd5);
        rom[22]  = uop(4'd1);
        rom[30]  = uop(4'd7);
        rom[31]  = uop(4'd1);
        rom[40]  = uop(4'd1);
        rom[464] = uop(4'd1);

        repeat (2) step();
        check("rst_mopreq", oMopReq, 1);
        check("rst_valid", oUopValid, 0);
        check("rst_uop", oUop, 0);
        check("rst_addr", oRomAddr, 0);
        check("rst_eof", oEof, 0);
        check("rst_ack", oIrqAck, 0);
        check("rst_ovf", oUpcOverflow, 0);
        iReset = 1'b1;
        step();

        // Default dispatch to 0, EOF there
        feed(8'h00);
        check("t1_addr", oRomAddr, 0);
        check("t1_valid", oUopValid, 1);
        check("t1_mopreq", oMopReq, 0);
        check("t1_uop", oUop, 13'h0200);
        step();
        check("t1_eof", oEof, 1);
        check("t1_fetch", oMopReq, 1);
        check("t1_valid_off", oUopValid, 0);
        step();
        check("t1_eof_pulse", oEof, 0);

        // Write and dispatch same index in one cycle: old entry used
        iCfgWe = 1'b1; iCfgSel = 1'b0; iCfgAddr = 8'h31; iCfgData = 9'd40;
        feed(8'h31);
        iCfgWe = 1'b0;
        check("wr_old_entry", oRomAddr, 0);
        step();
        check("wr_old_eof", oEof, 1);
        feed(8'h31);
        check("wr_new_entry", oRomAddr, 40);
        step();
        check("wr_new_eof", oEof, 1);
        cfg(1'b0, 8'h31, 9'd1);

        // Sequential walk with stall
        feed(8'h31);
        check("t2_addr1", oRomAddr, 1);
        step();
        check("t2_addr2", oRomAddr, 2);
        iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_stall_addr", oRomAddr, 2);
            check("t2_stall_uop", oUop, 13'h01a5);
            check("t2_stall_eof", oEof, 0);
        end
        iStall = 1'b0;
        step();
        check("t2_addr3", oRomAddr, 3);
        step();
        check("t2_ctrl9_cont", oRomAddr, 4);
        step();
        check("t2_eof", oEof, 1);
        check("t2_fetch", oMopReq, 1);

        // EOF_NZ with Z=0 ends, with Z=1 continues
        cfg(1'b0, 8'h20, 9'd17);
        iFlags = 4'b0000;
        feed(8'h20);
        check("t3a_17", oRomAddr, 17);
        step();
        step();
        check("t3a_19", oRomAddr, 19);
        step();
        check("t3a_eof", oEof, 1);
        check("t3a_fetch", oMopReq, 1);
        iFlags = 4'b1001;
        feed(8'h20);
        step();
        step();
        check("t3b_19", oRomAddr, 19);
        step();
        check("t3b_20", oRomAddr, 20);
        check("t3b_no_eof", oEof, 0);
        step();
        check("t3b_nc_cont", oRomAddr, 21);
        step();
        check("t3b_22", oRomAddr, 22);
        step();
        check("t3b_eof", oEof, 1);
        iFlags = 4'b0000;

        // CB prefix dispatch
        cfg(1'b0, 8'hCB, 9'd13);
        cfg(1'b1, 8'h7C, 9'd16);
        feed(8'hCB);
        check("t4_13", oRomAddr, 13);
        step();
        step();
        check("t4_15", oRomAddr, 15);
        step();
        check("t4_cbwait_req", oMopReq, 1);
        check("t4_cbwait_valid", oUopValid, 0);
        check("t4_cbwait_uop", oUop, 0);
        step();
        check("t4_cbwait_hold", oMopReq, 1);
        feed(8'h7C);
        check("t4_cb16", oRomAddr, 16);
        check("t4_exec", oUopValid, 1);
        step();
        check("t4_eof", oEof, 1);

        // Interrupt entry at end of flow
        cfg(1'b0, 8'h40, 9'd5);
        iIme = 1'b1;
        iIrq = 5'b10100;
        feed(8'h40);
        check("t5_5", oRomAddr, 5);
        check("t5_noack", oIrqAck, 0);
        step();
        check("t5_eof", oEof, 1);
        check("t5_ack", oIrqAck, 5'b00100);
        check("t5_vec", oRomAddr, 464);
        check("t5_exec", oUopValid, 1);
        iIrq = 5'b00000;
        step();
        check("t5_ack_pulse", oIrqAck, 0);
        check("t5_eof2", oEof, 1);
        check("t5_fetch", oMopReq, 1);
        iIme = 1'b0;
        iIrq = 5'b10100;
        feed(8'h40);
        step();
        check("t5_noime_eof", oEof, 1);
        check("t5_noime_ack", oIrqAck, 0);
        check("t5_noime_fetch", oMopReq, 1);
        iIrq = 5'b00000;

        // HALT wakes on any request without ack
        cfg(1'b0, 8'h76, 9'd30);
        feed(8'h76);
        check("t6_30", oRomAddr, 30);
        step();
        check("t6_halt_valid", oUopValid, 0);
        check("t6_halt_req", oMopReq, 0);
        step();
        check("t6_halt_hold", oUopValid, 0);
        iIrq = 5'b00010;
        step();
        check("t6_wake", oRomAddr, 31);
        check("t6_wake_valid", oUopValid, 1);
        check("t6_wake_noack", oIrqAck, 0);
        iIrq = 5'b00000;
        step();
        check("t6_eof", oEof, 1);

        // Micro-PC wrap and sticky overflow
        cfg(1'b0, 8'hFF, 9'd510);
        feed(8'hFF);
        check("t7_510", oRomAddr, 510);
        check("t7_noovf", oUpcOverflow, 0);
        step();
        check("t7_511", oRomAddr, 511);
        step();
        check("t7_wrap", oRomAddr, 0);
        check("t7_ovf", oUpcOverflow, 1);
        step();
        check("t7_eof", oEof, 1);
        check("t7_ovf_sticky", oUpcOverflow, 1);

        // Asynchronous reset mid-flow
        feed(8'h31);
        step();
        check("t8_mid", oRomAddr, 2);
        iReset = 1'b0;
        #1;
        check("t8_async_addr", oRomAddr, 0);
        check("t8_async_valid", oUopValid, 0);
        check("t8_async_ovf", oUpcOverflow, 0);
        check("t8_async_req", oMopReq, 1);
        step();
        check("t8_no_eof", oEof, 0);
        iReset = 1'b1;
        feed(8'h31);
        check("t8_tbl_reset", oRomAddr, 0);
        step();
        check("t8_eof", oEof, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dzcpu_ucode_sequencer.md
Name: dzcpu_ucode_sequencer

Overview:
Parametrised micro-sequencer for the dzcpu core. It owns the micro-PC, two run-time-loadable dispatch tables (primary opcode and CB-prefix), conditional end-of-flow evaluation and interrupt flow entry. It addresses an external combinational micro-op ROM and drives the current micro-op to the datapath. It sits between the fetch unit (macro-op byte) and the dzcpu datapath/flag unit.

Parameters:
MOP_W, 8, macro-op width; each dispatch table has 2^MOP_W entries
UPC_W, 9, micro-PC width; micro-ROM depth 2^UPC_W
UOP_W, 13, micro-op width
CTRL_LSB, 9, LSB of the 4-bit sequencing field uop[CTRL_LSB+3:CTRL_LSB]
DEFAULT_FLOW, 0, reset value of every dispatch entry
NUM_IRQ, 5, interrupt request lines
INT_FLOW_BASE, 448, micro-PC of the IRQ0 service flow
INT_FLOW_STRIDE, 8, spacing between IRQ service flows

Ports:
iClock  in  1  clock; all state updates on rising edge
iReset  in  1  asynchronous, active-low reset
iMop  in  MOP_W  macro-op byte from fetch
iMopValid  in  1  iMop is valid this cycle
oMopReq  out  1  sequencer is waiting for a macro-op byte
iStall  in  1  datapath or memory not ready; hold current micro-op
iFlags  in  4  {Z,N,H,C}
iIme  in  1  interrupt master enable
iIrq  in  NUM_IRQ  pending interrupt requests, level
oIrqAck  out  NUM_IRQ  one-hot, one-cycle acknowledge
oRomAddr  out  UPC_W  micro-ROM address (= micro-PC)
iRomData  in  UOP_W  micro-ROM data, combinational from oRomAddr
oUop  out  UOP_W  current micro-op
oUopValid  out  1  oUop is to be executed this cycle
oEof  out  1  one-cycle pulse: macro-op flow completed
iCfgWe  in  1  dispatch-table write strobe
iCfgSel  in  1  0 = primary table, 1 = CB table
iCfgAddr  in  MOP_W  table index
iCfgData  in  UPC_W  flow start address
oUpcOverflow  out  1  sticky: micro-PC wrapped

Behaviour:
- Reset (iReset=0, asynchronous): state=FETCH, uPC=0, both tables all DEFAULT_FLOW, oIrqAck=0, oEof=0, oUpcOverflow=0, oUopValid=0.
- oRomAddr=uPC. oUop=iRomData when oUopValid, else 0. oUopValid=1 only in EXEC.
- States: FETCH, EXEC, CBWAIT, HALT. oMopReq=1 in FETCH and CBWAIT.
- FETCH: on iMopValid, uPC<=primary[iMop] and go to EXEC; otherwise hold.
- EXEC with iStall=1: hold uPC and state, keep oUop stable, no pulses.
- EXEC with iStall=0, decode ctrl=uop[CTRL_LSB+3:CTRL_LSB]:
  - 0 CONT: uPC<=uPC+1.
  - 1 EOF: take end-of-flow.
  - 2 EOF_Z: end-of-flow if Z=1, else CONT.
  - 3 EOF_NZ: end-of-flow if Z=0, else CONT.
  - 4 EOF_C: end-of-flow if C=1, else CONT.
  - 5 EOF_NC: end-of-flow if C=0, else CONT.
  - 6 JCB: go to CBWAIT.
  - 7 HALT: go to HALT.
  - 8-15: treated as CONT.
- End-of-flow: oEof=1 for the next cycle. If iIme=1 and iIrq!=0, select k = lowest set bit; uPC<=INT_FLOW_BASE+k*INT_FLOW_STRIDE; oIrqAck[k]=1 for one cycle; stay in EXEC. Otherwise go to FETCH.
- CBWAIT: on iMopValid, uPC<=cb[iMop] and go to EXEC.
- HALT: when iIrq!=0 (regardless of iIme), uPC<=uPC+1 and go to EXEC. No ack is issued.
- Flags are sampled in the same cycle as the conditional micro-op.
- uPC+1 is computed mod 2^UPC_W. A wrap from all-ones to 0 sets oUpcOverflow, which clears only on reset.
- Config writes take effect on the next edge and are allowed in any state.
- A write and a dispatch to the same index in the same cycle: the dispatch uses the old entry.
- Reset asserted mid-flow aborts immediately; no oEof is produced.

Test Plan:
- Reset, then iMop=0x00 valid: FETCH→EXEC with uPC=0; ROM[0] ctrl=EOF → oEof pulse, return to FETCH, oMopReq=1.
- Load primary[0x31]=1; ROM[1..3]=CONT, ROM[4]=EOF; feed 0x31 → oRomAddr walks 1,2,3,4 with oUopValid=1; hold iStall=1 at uPC=2 for 3 cycles → oRomAddr stays 2 and oUop is stable.
- Flow at 17 with ROM[19]=EOF_NZ: Z=0 → oEof and FETCH after uPC=19; Z=1 → uPC proceeds to 20, 21, 22.
- Primary[0xCB]=13, ROM[15]=JCB, cb[0x7C]=16: feed 0xCB, then wait 2 idle cycles, then 0x7C → CBWAIT holds oMopReq=1 for 2 cycles, then uPC=16.
- iIme=1, iIrq=5'b10100 at an EOF → uPC=INT_FLOW_BASE+2*8=464, oIrqAck=5'b00100 for 1 cycle; repeat with iIme=0 → return to FETCH, no ack.
- ROM[511]=CONT → uPC wraps to 0 and oUpcOverflow=1 and stays 1; assert reset mid-flow → all outputs return to their reset values asynchronously.
